// File: rtl/opb_status_word_scheduler.sv
// Purpose : round-robin sharing of one 32-bit status register among N_SRC producers;
//           each queued word is held HOLD_CYCLES cycles, tagged {idx[3:0], seq[3:0]}.
// Latency : strobe at edge t into an idle, enabled, empty block -> status_vld at edge t+1;
//           back-to-back words are HOLD_CYCLES+1 cycles apart.
// Backpressure: none towards producers. Re-strobing a source that is still pending
//           overwrites its older word (latest wins) and bumps saturating drop_cnt.
//
// Ports:
//   user_clk, user_rst_n  clock and asynchronous active-low reset
//   sched_en              1 = grants allowed; 0 = finish current hold, then stay idle
//   src_stb / src_data    per-source capture strobe and DATA_W-bit payload slices
//   status_word           {idx, seq, data} towards the simulink2ppc user_data_in
//   status_vld            one-cycle pulse when status_word is loaded
//   busy                  high while a word is being held
//   pend                  per-source pending flags
//   drop_cnt              saturating count of words overwritten before emission
//
// Optional feature: define STATUS_SCHED_HEARTBEAT_EN to emit a heartbeat word
// {4'hF, seq, heartbeat_cnt} after IDLE_TIMEOUT idle cycles with nothing pending.
module opb_status_word_scheduler #(
    parameter int N_SRC        = 4,
    parameter int DATA_W       = 24,
    parameter int HOLD_CYCLES  = 64,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic                      user_clk,
    input  logic                      user_rst_n,
    input  logic                      sched_en,
    input  logic [N_SRC-1:0]          src_stb,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [31:0]               status_word,
    output logic                      status_vld,
    output logic                      busy,
    output logic [N_SRC-1:0]          pend,
    output logic [15:0]               drop_cnt
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // An illegal configuration shows up as this named block in the elaborated hierarchy.
    if (N_SRC < 2 || N_SRC > 15 || DATA_W != 24 || HOLD_CYCLES < 2 || IDLE_TIMEOUT < 2)
    begin : g_illegal_params
    end

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  shadow [N_SRC];
    logic [3:0]         last_grant;
    logic [3:0]         seq;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               gnt_found;
    logic [3:0]         gnt_idx;
    logic [4:0]         cand;
    logic [DATA_W-1:0]  gnt_data;
    logic               gnt_fire;
    logic               hb_fire;
    logic [DATA_W-1:0]  hb_data;
    logic               emit;

    logic [N_SRC-1:0]   gnt_oh;
    logic [N_SRC-1:0]   pend_nxt;
    logic [N_SRC-1:0]   drops;
    logic [4:0]         drop_sum;
    logic [16:0]        drop_total;
    logic [15:0]        drop_nxt;

    // Round-robin search: first pending source after last_grant, in cyclic order.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = {1'b0, last_grant} + 5'(k);
            if (cand >= 5'(N_SRC)) begin
                cand = cand - 5'(N_SRC);
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (!gnt_found && pend[i] && cand == 5'(i)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 4'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == 4'(i)) begin
                gnt_data = shadow[i];
            end
        end
    end

    assign gnt_fire = (state == S_IDLE) && sched_en && gnt_found;

    // Pending/drop bookkeeping. A strobe on the granted source's grant edge re-arms
    // pend for the new word while the old shadow value is emitted: not a drop.
    always_comb begin
        gnt_oh   = '0;
        drop_sum = '0;
        for (int i = 0; i < N_SRC; i++) begin
            gnt_oh[i] = gnt_fire && (gnt_idx == 4'(i));
        end
        pend_nxt = src_stb | (pend & ~gnt_oh);
        drops    = src_stb & pend & ~gnt_oh;
        for (int i = 0; i < N_SRC; i++) begin
            drop_sum = drop_sum + {4'b0, drops[i]};
        end
        drop_total = {1'b0, drop_cnt} + {12'b0, drop_sum};
        drop_nxt   = drop_total[16] ? 16'hFFFF : drop_total[15:0];
    end

`ifdef STATUS_SCHED_HEARTBEAT_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic [DATA_W-1:0] hb_cnt;

    assign hb_fire = (state == S_IDLE) && (pend == '0) && sched_en && (idle_cnt == IDLE_LAST);
    assign hb_data = hb_cnt;

    // Idle counter runs only in IDLE with nothing pending; it parks at its last value
    // while disabled so the heartbeat fires as soon as scheduling is re-enabled.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            idle_cnt <= '0;
            hb_cnt   <= '0;
        end else if (hb_fire) begin
            idle_cnt <= '0;
            hb_cnt   <= hb_cnt + 1'b1;
        end else if (state == S_IDLE && pend == '0) begin
            if (idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign hb_fire = 1'b0;
    assign hb_data = '0;
`endif

    // FSM: state register
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (gnt_fire || hb_fire) state_nxt = S_HOLD;
            S_HOLD: if (hold_cnt == '0)      state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == S_HOLD);
        emit = gnt_fire || hb_fire;
    end

    // Datapath: shadows, pending flags, emitted word, sequence and hold counter.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            status_word <= '0;
            status_vld  <= 1'b0;
            pend        <= '0;
            drop_cnt    <= '0;
            seq         <= '0;
            last_grant  <= 4'(N_SRC - 1);
            hold_cnt    <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            pend       <= pend_nxt;
            drop_cnt   <= drop_nxt;
            status_vld <= emit;
            for (int i = 0; i < N_SRC; i++) begin
                if (src_stb[i]) begin
                    shadow[i] <= src_data[i*DATA_W +: DATA_W];
                end
            end
            if (gnt_fire) begin
                status_word <= {gnt_idx, seq, gnt_data};
                last_grant  <= gnt_idx;
            end else if (hb_fire) begin
                status_word <= {4'hF, seq, hb_data};
            end
            if (emit) begin
                seq      <= seq + 4'd1;
                hold_cnt <= HOLD_LAST;
            end else if (state == S_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule
